// File: rtl/n64a_vmux.sv
// n64a_vmux: N64 video bus multiplexer.
// Buffers pixels in a 2-deep FIFO and serialises sync/R/G/B per 4-cycle slot.
module n64a_vmux #(
  parameter int color_width = 7
) (
  input  logic                         VCLK,
  input  logic                         nRST,
  input  logic [1:0]                   muxparams_i,
  input  logic [4+3*color_width-1:0]   vdata_i,
  input  logic                         vdata_valid_i,
  output logic                         vdata_ready_o,
  output logic                         nVDSYNC_o,
  output logic [color_width-1:0]       VD_o,
  output logic                         underrun_o
);

  localparam int CW = color_width;
  localparam int DW = 4 + 3 * CW;

  logic [1:0]    phase;
  logic [DW-1:0] mem [2];
  logic          wr_ptr;
  logic          rd_ptr;
  logic [1:0]    count;
  logic [DW-1:0] tx;
  logic          toggle;
  logic          armed;
  logic          full_col;

  logic boundary;
  logic due;
  logic push;
  logic pop;
  logic bypass;
  logic starve;
  logic wr;

  assign vdata_ready_o = (count != 2'd2);
  assign push     = vdata_valid_i & vdata_ready_o;
  assign boundary = (phase == 2'd3);
  assign due      = boundary & (~muxparams_i[1] | ~toggle);
  assign pop      = due & (count != 2'd0);
  assign bypass   = due & (count == 2'd0) & push;
  assign starve   = due & (count == 2'd0) & ~push;
  assign wr       = push & ~bypass;

  function automatic logic [CW-1:0] shade(
    input logic [CW-1:0] c,
    input logic          full
  );
    return full ? c : {c[CW-1:2], 2'b00};
  endfunction

  always_ff @(posedge VCLK) begin
    if (wr) mem[wr_ptr] <= vdata_i;
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (wr) wr_ptr <= ~wr_ptr;
      if (pop) rd_ptr <= ~rd_ptr;
      unique case ({wr, pop})
        2'b10:   count <= count + 2'd1;
        2'b01:   count <= count - 2'd1;
        default: count <= count;
      endcase
    end
  end

  // An empty FIFO at the boundary forwards the incoming pixel straight to tx.
  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      phase      <= 2'd0;
      tx         <= {4'hF, {(3*CW){1'b0}}};
      toggle     <= 1'b0;
      armed      <= 1'b0;
      underrun_o <= 1'b0;
      full_col   <= 1'b1;
    end else begin
      phase <= phase + 2'd1;
      if (push) armed <= 1'b1;
      if (boundary) begin
        full_col <= muxparams_i[0];
        if (pop) tx <= mem[rd_ptr];
        else if (bypass) tx <= vdata_i;
        toggle <= muxparams_i[1] & ~toggle & (pop | bypass);
        if (starve & armed) underrun_o <= 1'b1;
      end
    end
  end

  always_ff @(posedge VCLK or negedge nRST) begin
    if (!nRST) begin
      nVDSYNC_o <= 1'b1;
      VD_o      <= '0;
    end else begin
      nVDSYNC_o <= (phase != 2'd0);
      unique case (phase)
        2'd0: VD_o <= {{(CW-4){1'b0}}, tx[DW-1 -: 4]};
        2'd1: VD_o <= shade(tx[3*CW-1 -: CW], full_col);
        2'd2: VD_o <= shade(tx[2*CW-1 -: CW], full_col);
        2'd3: VD_o <= shade(tx[CW-1:0], full_col);
        default: VD_o <= '0;
      endcase
    end
  end

endmodule

// File: tb/tb_n64a_vmux.sv
// tb_n64a_vmux: scoreboard bench for the video multiplexer.
// A pixel-level reference model queues expected bus words; a monitor compares.
module tb_n64a_vmux;

  localparam int CW = 7;
  localparam int DW = 4 + 3 * CW;

  logic          VCLK = 1'b0;
  logic          nRST = 1'b0;
  logic [1:0]    muxparams_i = 2'b01;
  logic [DW-1:0] vdata_i = '0;
  logic          vdata_valid_i = 1'b0;
  logic          vdata_ready_o;
  logic          nVDSYNC_o;
  logic [CW-1:0] VD_o;
  logic          underrun_o;

  int errors = 0;
  int checks = 0;

  always #5 VCLK = ~VCLK;

  n64a_vmux #(.color_width(CW)) dut (
    .VCLK          (VCLK),
    .nRST          (nRST),
    .muxparams_i   (muxparams_i),
    .vdata_i       (vdata_i),
    .vdata_valid_i (vdata_valid_i),
    .vdata_ready_o (vdata_ready_o),
    .nVDSYNC_o     (nVDSYNC_o),
    .VD_o          (VD_o),
    .underrun_o    (underrun_o)
  );

  // reference model state
  logic [DW-1:0] mq[$];
  logic [CW:0]   exp_q[$];
  logic [DW-1:0] cur;
  int            owe;
  bit            armed;
  bit            urun;
  bit            live;
  int            cyc;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [CW-1:0] shade(input logic [CW-1:0] c,
                                          input bit full);
    return full ? c : CW'((c / 4) * 4);
  endfunction

  task automatic push_slot(input logic [DW-1:0] p, input bit full);
    logic [3:0]    s;
    logic [CW-1:0] r;
    logic [CW-1:0] g;
    logic [CW-1:0] b;
    s = p[DW-1 -: 4];
    r = p[3*CW-1 -: CW];
    g = p[2*CW-1 -: CW];
    b = p[CW-1:0];
    exp_q.push_back({1'b0, CW'(s)});
    exp_q.push_back({1'b1, shade(r, full)});
    exp_q.push_back({1'b1, shade(g, full)});
    exp_q.push_back({1'b1, shade(b, full)});
  endtask

  task automatic model_reset();
    mq.delete();
    exp_q.delete();
    cur   = {4'hF, {(3*CW){1'b0}}};
    owe   = 0;
    armed = 0;
    urun  = 0;
    live  = 0;
    cyc   = 0;
    push_slot(cur, 1'b1);
  endtask

  // Slot-level behaviour: each pixel owes one extra slot while repeating.
  always @(posedge VCLK) begin
    if (nRST) begin
      if (vdata_valid_i && mq.size() < 2) begin
        mq.push_back(vdata_i);
        armed = 1;
      end
      if (cyc == 3) begin
        if (muxparams_i[1] && owe > 0) begin
          owe = 0;
        end else if (mq.size() > 0) begin
          cur = mq.pop_front();
          owe = muxparams_i[1] ? 1 : 0;
        end else begin
          owe = 0;
          if (armed) urun = 1;
        end
        push_slot(cur, muxparams_i[0]);
      end
      cyc  = (cyc + 1) % 4;
      live = 1;
    end
  end

  always @(negedge VCLK) begin
    logic [CW:0] e;
    if (!nRST) begin
      chk("rst_nsync", 32'(nVDSYNC_o), 32'd1);
      chk("rst_vd", 32'(VD_o), 32'd0);
      chk("rst_ready", 32'(vdata_ready_o), 32'd1);
      chk("rst_underrun", 32'(underrun_o), 32'd0);
    end else if (live) begin
      if (exp_q.size() == 0) begin
        chk("exp_queue_empty", 32'd0, 32'd1);
      end else begin
        e = exp_q.pop_front();
        chk("bus_word", 32'({nVDSYNC_o, VD_o}), 32'(e));
      end
      chk("ready", 32'(vdata_ready_o), 32'(mq.size() < 2));
      chk("underrun", 32'(underrun_o), 32'(urun));
    end
  end

  task automatic tick();
    @(posedge VCLK);
    #1;
  endtask

  task automatic do_reset(input int n);
    nRST = 1'b0;
    vdata_valid_i = 1'b0;
    model_reset();
    repeat (n) tick();
    nRST = 1'b1;
  endtask

  function automatic logic [DW-1:0] mkpix();
    return DW'($urandom);
  endfunction

  task automatic push_pix(input logic [DW-1:0] p);
    int n;
    n = 0;
    vdata_i = p;
    vdata_valid_i = 1'b1;
    while (!vdata_ready_o && n < 64) begin
      tick();
      n++;
    end
    if (n >= 64) chk("push_timeout", 32'd0, 32'd1);
    tick();
    vdata_valid_i = 1'b0;
  endtask

  task automatic feed(input int n);
    logic r;
    vdata_i = mkpix();
    vdata_valid_i = 1'b1;
    repeat (n) begin
      r = vdata_ready_o;
      tick();
      if (r) vdata_i = mkpix();
    end
    vdata_valid_i = 1'b0;
  endtask

  initial begin
    logic [DW-1:0] px;
    int n;
    px = {4'hE, 7'h55, 7'h2A, 7'h7F};
    model_reset();
    #1;
    repeat (3) tick();
    nRST = 1'b1;

    // single pixel, full and reduced colour
    muxparams_i = 2'b01;
    push_pix(px);
    repeat (12) tick();
    muxparams_i = 2'b00;
    push_pix(px);
    repeat (12) tick();

    // pixel repeat with two back-to-back pushes
    do_reset(2);
    muxparams_i = 2'b11;
    push_pix(mkpix());
    push_pix(mkpix());
    repeat (24) tick();

    // starve after one pixel: resend and sticky underrun
    do_reset(2);
    muxparams_i = 2'b01;
    push_pix(mkpix());
    repeat (16) tick();
    chk("underrun_sticky", 32'(underrun_o), 32'd1);

    // continuous feed over 64 slots
    do_reset(2);
    muxparams_i = 2'b01;
    feed(64 * 4);
    vdata_valid_i = 1'b0;
    chk("no_underrun_stream", 32'(underrun_o), 32'd0);
    repeat (8) tick();

    // reset in phase 2 with two pixels buffered
    do_reset(2);
    muxparams_i = 2'b01;
    vdata_valid_i = 1'b1;
    vdata_i = mkpix();
    n = 0;
    while (!(cyc == 2 && mq.size() == 2) && n < 200) begin
      if (vdata_ready_o) begin
        tick();
        vdata_i = mkpix();
      end else begin
        tick();
      end
      n++;
    end
    if (n >= 200) chk("fill_timeout", 32'd0, 32'd1);
    nRST = 1'b0;
    vdata_valid_i = 1'b0;
    model_reset();
    #1;
    chk("midrst_nsync", 32'(nVDSYNC_o), 32'd1);
    chk("midrst_vd", 32'(VD_o), 32'd0);
    chk("midrst_ready", 32'(vdata_ready_o), 32'd1);
    repeat (2) tick();
    nRST = 1'b1;
    repeat (12) tick();

    // randomized traffic with mode changes at arbitrary cycles
    do_reset(2);
    repeat (800) begin
      muxparams_i   = 2'($urandom_range(0, 3));
      vdata_valid_i = ($urandom_range(0, 99) < 45);
      vdata_i       = mkpix();
      tick();
    end
    vdata_valid_i = 1'b0;
    repeat (8) tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
